seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have parameter STABLE, default 4, the number of consecutive identical bus samples required before a digit is accepted (legal range 2..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 65536, the number of cycles without a completed frame before stale asserts (legal range ≥16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port an, input, 4, digit enables, active-low, with an[i] selecting digit i and digit 3 as the most significant nibble.
REQ-006 The block SHALL have port seg, input, 7, segments, active-high, with seg[0]=a through seg[6]=g.
REQ-007 The block SHALL have port value, output, 16, the last complete captured word.
REQ-008 The block SHALL have port valid, output, 1, a one-cycle pulse when value updates.
REQ-009 The block SHALL have port err, output, 1, a one-cycle pulse on an accepted dwell with an unknown pattern.
REQ-010 The block SHALL have port err_digit, output, 2, the digit index of the last err; it holds between errs.
REQ-011 The block SHALL have port stale, output, 1, asserted when no frame has completed within TIMEOUT cycles.

Function
REQ-012 The block SHALL decode the pattern table g..a to nibble as follows: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F; any other pattern is invalid.
REQ-013 The block SHALL register the sample {an,seg} in prev each cycle; a sample differing from prev SHALL set cnt=1 and re-arm, and an identical sample SHALL increment cnt, saturating at STABLE.
REQ-014 A dwell SHALL be accepted exactly once, on the edge of the STABLE-th consecutive identical sample; further identical samples SHALL NOT re-accept it.
REQ-015 An accepted dwell SHALL be ignored, with no capture and no err, when an is not one-cold (all-high blanking or multiple low).
REQ-016 An accepted dwell with one-cold an and a valid pattern SHALL write the nibble into shadow slot i and set seen[i]; rewriting a slot before frame completion overwrites it.
REQ-017 An accepted dwell with one-cold an and an invalid pattern SHALL pulse err, load err_digit=i, leave slot i and seen[i] unchanged, and SHALL NOT clear other seen bits.
REQ-018 On the edge where seen becomes 4'hF, the block SHALL load value from the shadow (including the nibble written that edge), pulse valid, clear seen, clear stale, and restart the timeout counter.
REQ-019 Capture latency SHALL be STABLE edges from the first changed sample to the slot write; valid SHALL be asserted in the cycle after that same edge.
REQ-020 The timeout counter SHALL increment every cycle without valid; on reaching TIMEOUT-1 it SHALL assert stale, clear seen, and hold saturated until the next valid.
REQ-021 A change at the cnt=STABLE-1 sample SHALL cancel acceptance, with cnt set to 1 for the new value.

Reset
REQ-022 On rst, the block SHALL set value=0, valid=0, err=0, err_digit=0, stale=1, seen=0, shadow=0, cnt=0, timeout=0, and prev={4'hF,7'h00}.
REQ-023 A reset asserted mid-frame SHALL discard partial slots; capture SHALL require a full new frame of four digits.
REQ-024 The block SHALL treat the first sample after reset, if non-blank, as a change relative to prev.

Structure
REQ-025 The 16 segment pattern constants and the blank constant SHALL reside in the shared include seg_defs.vh, reused by the forward decoder.
REQ-026 The block SHALL instantiate one combinational sub-module, seg_to_hex (pattern[6:0] -> nibble[3:0], ok), and all state SHALL reside in seg_capture.
REQ-027 The implementation SHALL be 120-400 lines of RTL.

Verification (STABLE=4, TIMEOUT=64)
REQ-028 Bench scenario: scan an=E,D,B,7 with seg=3F,06,5B,4F for 6 cycles each -> a single valid pulse with value=16'h3210 after the 4th digit's 4th sample.
REQ-029 Bench scenario: digit 1 held only 3 cycles, then blanked -> no capture, seen[1]=0, no valid.
REQ-030 Bench scenario: digit 2 driven with pattern 7'h00 for 5 cycles -> err for exactly 1 cycle, err_digit=2, and no valid until digit 2 is later driven with 7'h7F.
REQ-031 Bench scenario: an=4'hC (two low) with seg=7F for 10 cycles -> no capture and no err.
REQ-032 Bench scenario: a complete frame followed by 64 idle cycles -> stale=1 at cycle 64 and value held; the next full frame -> valid and stale=0.
REQ-033 Bench scenario: rst pulsed after three digits are captured, then the fourth digit alone is scanned -> no valid; a full rescan yields the correct value.

Source files
------------

// File: rtl/seg_capture_pkg.sv
// Shared types and an-decoding helpers for the seven-segment capture block.
package seg_capture_pkg;

  localparam logic [3:0] AN_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

  // Exactly one digit enable pulled low.
  function automatic logic one_cold(input logic [3:0] an);
    case (an)
      4'hE, 4'hD, 4'hB, 4'h7: one_cold = 1'b1;
      default:                one_cold = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] cold_idx(input logic [3:0] an);
    case (an)
      4'hD:    cold_idx = 2'd1;
      4'hB:    cold_idx = 2'd2;
      4'h7:    cold_idx = 2'd3;
      default: cold_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_defs.vh
// Segment patterns (g..a, active-high) shared by the encoder and decoder sides.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH
`define SEG_0     7'h3F
`define SEG_1     7'h06
`define SEG_2     7'h5B
`define SEG_3     7'h4F
`define SEG_4     7'h66
`define SEG_5     7'h6D
`define SEG_6     7'h7D
`define SEG_7     7'h07
`define SEG_8     7'h7F
`define SEG_9     7'h6F
`define SEG_A     7'h77
`define SEG_B     7'h7C
`define SEG_C     7'h39
`define SEG_D     7'h5E
`define SEG_E     7'h79
`define SEG_F     7'h71
`define SEG_BLANK 7'h00
`endif

// File: rtl/seg_to_hex.sv
// Combinational segment-pattern to hex-nibble decoder; ok low for unknown patterns.
// Zero latency, no flow control.
`include "seg_defs.vh"

module seg_to_hex
  import seg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    nibble = 4'h0;
    ok     = 1'b1;
    case (pattern)
      `SEG_0: nibble = 4'h0;
      `SEG_1: nibble = 4'h1;
      `SEG_2: nibble = 4'h2;
      `SEG_3: nibble = 4'h3;
      `SEG_4: nibble = 4'h4;
      `SEG_5: nibble = 4'h5;
      `SEG_6: nibble = 4'h6;
      `SEG_7: nibble = 4'h7;
      `SEG_8: nibble = 4'h8;
      `SEG_9: nibble = 4'h9;
      `SEG_A: nibble = 4'hA;
      `SEG_B: nibble = 4'hB;
      `SEG_C: nibble = 4'hC;
      `SEG_D: nibble = 4'hD;
      `SEG_E: nibble = 4'hE;
      `SEG_F: nibble = 4'hF;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Recovers a 16-bit word from a multiplexed seven-segment scan; STABLE-sample debounce per digit.
// Slot write STABLE edges after a change, valid one cycle later; no backpressure (pulses only).
`include "seg_defs.vh"

module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_digit,
  output logic        stale
);

  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TPRE    = TW'(TIMEOUT - 2);
  localparam logic [7:0]    CNT_SAT = 8'(STABLE);
  localparam logic [7:0]    CNT_ARM = 8'(STABLE - 1);

  sample_t       sample, prev;
  logic [7:0]    cnt;
  logic [3:0]    seen, seen_nx;
  logic [15:0]   shadow, shadow_nx;
  logic [TW-1:0] tmo;

  logic       same, accept, live, cap, bad, complete, ok;
  logic [1:0] idx;
  logic [3:0] nib;

  seg_to_hex u_dec (
    .pattern (seg),
    .nibble  (nib),
    .ok      (ok)
  );

  // Acceptance fires only on the edge cnt climbs to STABLE, so it happens once per dwell.
  always_comb begin
    sample    = '{an: an, seg: seg};
    same      = (sample == prev);
    accept    = same && (cnt == CNT_ARM);
    live      = accept && one_cold(an);
    idx       = cold_idx(an);
    cap       = live && ok;
    bad       = live && !ok;
    shadow_nx = shadow;
    seen_nx   = seen;
    if (cap) begin
      shadow_nx[{idx, 2'b00} +: 4] = nib;
      seen_nx[idx]                 = 1'b1;
    end
    complete = cap && (seen_nx == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '{an: AN_BLANK, seg: `SEG_BLANK};
      cnt       <= 8'd0;
      seen      <= 4'h0;
      shadow    <= 16'h0;
      value     <= 16'h0;
      valid     <= 1'b0;
      err       <= 1'b0;
      err_digit <= 2'd0;
      stale     <= 1'b1;
      tmo       <= '0;
    end else begin
      prev  <= sample;
      valid <= complete;
      err   <= bad;
      if (!same)
        cnt <= 8'd1;
      else if (cnt != CNT_SAT)
        cnt <= cnt + 8'd1;
      if (bad)
        err_digit <= idx;
      shadow <= shadow_nx;
      if (complete) begin
        value <= shadow_nx;
        seen  <= 4'h0;
        stale <= 1'b0;
        tmo   <= '0;
      end else begin
        seen <= seen_nx;
        // Partial frames are dropped once when the counter saturates; later digits start afresh.
        if (tmo != TMAX) begin
          tmo <= tmo + TW'(1);
          if (tmo == TPRE) begin
            stale <= 1'b1;
            seen  <= 4'h0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: expected words/err digits queued at drive time, checked on pulses.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic [1:0]  err_digit;
  logic        stale;

  int checks = 0;
  int errors = 0;

  logic [15:0] val_q[$];
  logic [1:0]  err_q[$];

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_capture #(.STABLE(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .an        (an),
    .seg       (seg),
    .value     (value),
    .valid     (valid),
    .err       (err),
    .err_digit (err_digit),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one sample for n rising edges, returning just after the last one.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int i, input logic [3:0] nib, input int n);
    logic [3:0] a;
    a = 4'hF;
    a[i] = 1'b0;
    hold(a, pat[nib], n);
  endtask

  task automatic scan_frame(input logic [15:0] v);
    for (int i = 0; i < 4; i++) digit(i, v[4*i +: 4], 6);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("valid_pending", 32'(val_q.size() > 0), 32'd1);
      if (val_q.size() > 0) chk("valid_value", 32'(value), 32'(val_q.pop_front()));
    end
    if (err) begin
      chk("err_pending", 32'(err_q.size() > 0), 32'd1);
      if (err_q.size() > 0) chk("err_digit", 32'(err_digit), 32'(err_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_digit", 32'(err_digit), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    rst = 1'b0;
    hold(4'hF, 7'h00, 4);

    // Basic frame with latency check on the final digit.
    val_q.push_back(16'h3210);
    hold(4'hE, 7'h3F, 6);
    hold(4'hD, 7'h06, 6);
    hold(4'hB, 7'h5B, 6);
    hold(4'h7, 7'h4F, 3);
    chk("valid_early", 32'(valid), 32'h0);
    @(posedge clk); #1;
    chk("valid_at_latency", 32'(valid), 32'h1);
    chk("value_at_latency", 32'(value), 32'h3210);
    @(posedge clk); #1;
    chk("valid_single_pulse", 32'(valid), 32'h0);
    chk("stale_cleared", 32'(stale), 32'h0);
    @(posedge clk); #1;

    // Short dwell on digit 1 must not count towards the frame.
    digit(0, 4'h5, 6);
    digit(1, 4'h9, 3);
    hold(4'hF, 7'h00, 4);
    digit(2, 4'hA, 6);
    digit(3, 4'hB, 6);
    chk("short_dwell_no_value", 32'(value), 32'h3210);
    val_q.push_back(16'hBAC5);
    digit(1, 4'hC, 6);

    // Unknown pattern on digit 2: one err pulse, no capture until a legal pattern arrives.
    digit(0, 4'h1, 6);
    digit(1, 4'h2, 6);
    err_q.push_back(2'd2);
    hold(4'hB, 7'h00, 5);
    digit(3, 4'h4, 6);
    chk("err_digit_holds", 32'(err_digit), 32'h2);
    chk("err_no_value", 32'(value), 32'hBAC5);
    val_q.push_back(16'h4821);
    hold(4'hB, 7'h7F, 6);

    // Two enables low at once is ignored entirely.
    digit(1, 4'hD, 6);
    digit(2, 4'hE, 6);
    digit(3, 4'hF, 6);
    hold(4'hC, 7'h7F, 10);
    chk("multi_low_no_value", 32'(value), 32'h4821);
    val_q.push_back(16'hFED7);
    digit(0, 4'h7, 6);

    // Timeout after a completed frame, then recovery.
    val_q.push_back(16'h9876);
    scan_frame(16'h9876);
    hold(4'hF, 7'h00, 58);
    chk("stale_before_timeout", 32'(stale), 32'h0);
    hold(4'hF, 7'h00, 5);
    chk("stale_after_timeout", 32'(stale), 32'h1);
    chk("value_held_stale", 32'(value), 32'h9876);
    val_q.push_back(16'h1357);
    scan_frame(16'h1357);
    chk("stale_recovered", 32'(stale), 32'h0);

    // Reset mid-frame discards partial slots.
    digit(0, 4'hA, 6);
    digit(1, 4'hB, 6);
    digit(2, 4'hC, 6);
    rst = 1'b1;
    hold(4'hF, 7'h00, 2);
    rst = 1'b0;
    chk("rst_mid_value", 32'(value), 32'h0);
    chk("rst_mid_stale", 32'(stale), 32'h1);
    digit(3, 4'hD, 6);
    hold(4'hF, 7'h00, 3);
    chk("partial_after_rst", 32'(value), 32'h0);
    val_q.push_back(16'hDCBA);
    scan_frame(16'hDCBA);
    hold(4'hF, 7'h00, 4);

    chk("val_q_drained", 32'(val_q.size()), 32'h0);
    chk("err_q_drained", 32'(err_q.size()), 32'h0);
    chk("final_value", 32'(value), 32'hDCBA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
